// File: rtl/butterfly_sequencer_if.sv
// Signal bundle between the butterfly sequencer, its word source, the
// downstream butterfly and the result consumer.
`timescale 1ns/1ps

interface butterfly_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] bfly_data;
  logic       bfly_ready;
  logic [7:0] bfly_result;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [1:0] res_tag;
  logic       w_pending;
  logic [7:0] frame_count;

  // Environment side: word source, butterfly LED output and result consumer.
  modport master (
    output in_valid, in_data, bfly_result, res_ready,
    input  in_ready, bfly_data, bfly_ready, res_valid, res_data, res_tag,
           w_pending, frame_count
  );

  modport slave (
    input  in_valid, in_data, bfly_result, res_ready,
    output in_ready, bfly_data, bfly_ready, res_valid, res_data, res_tag,
           w_pending, frame_count
  );
endinterface

// File: rtl/butterfly_sequencer.sv
// Feeds operand words to a push-button butterfly as timed ReadyIn pulses and
// captures the four displayed results (Re y, Im y, Re z, Im z) of every frame.
`timescale 1ns/1ps

module butterfly_sequencer #(
  parameter int HOLD_CYCLES = 8
) (
  input logic            clk,
  input logic            reset,
  butterfly_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  // Pulse index: W0, W1, then P0..P6.
  localparam logic [3:0] IDX_W0 = 4'd0;
  localparam logic [3:0] IDX_W1 = 4'd1;
  localparam logic [3:0] IDX_P0 = 4'd2;
  localparam logic [3:0] IDX_P3 = 4'd5;
  localparam logic [3:0] IDX_P6 = 4'd8;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  logic [1:0] state;
  logic [3:0] idx;
  logic [7:0] hold_cnt;
  logic       armed;
  logic [7:0] bfly_data_q;
  logic       res_valid_q;
  logic [7:0] res_data_q;
  logic [1:0] res_tag_q;
  logic       w_pending_q;
  logic [7:0] frame_cnt_q;

  logic consumes;
  logic captures;
  logic blocked;
  logic start;
  logic phase_end;

  // armed is low for the first cycle after reset so no word is taken then.
  assign consumes  = (idx <= IDX_P3);
  assign captures  = (idx >= IDX_P3);
  assign blocked   = captures && res_valid_q && !bus.res_ready;
  assign start     = (state == S_IDLE) && armed && !reset && !blocked &&
                     (!consumes || bus.in_valid);
  assign phase_end = (hold_cnt == 8'd0);

  assign bus.in_ready    = start && consumes;
  assign bus.bfly_ready  = (state == S_HIGH);
  assign bus.bfly_data   = bfly_data_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_tag     = res_tag_q;
  assign bus.w_pending   = w_pending_q;
  assign bus.frame_count = frame_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= IDX_W0;
      hold_cnt    <= 8'd0;
      armed       <= 1'b0;
      bfly_data_q <= 8'h00;
      res_valid_q <= 1'b0;
      res_data_q  <= 8'h00;
      res_tag_q   <= 2'd0;
      w_pending_q <= 1'b1;
      frame_cnt_q <= 8'd0;
    end else begin
      armed <= 1'b1;
      // NOTE: the capture below is assigned later in this block, so a capture
      // in the same cycle as an accept wins and res_valid stays set.
      if (res_valid_q && bus.res_ready) res_valid_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            if (consumes) bfly_data_q <= bus.in_data;
            state    <= S_HIGH;
            hold_cnt <= HOLD_LOAD;
          end
        end
        S_HIGH: begin
          if (phase_end) begin
            state    <= S_LOW;
            hold_cnt <= HOLD_LOAD;
            if (captures) begin
              res_data_q  <= bus.bfly_result;
              res_tag_q   <= 2'(idx - IDX_P3);
              res_valid_q <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        S_LOW: begin
          if (phase_end) begin
            state <= S_IDLE;
            if (idx == IDX_W1) w_pending_q <= 1'b0;
            if (idx == IDX_P6) begin
              idx         <= IDX_P0;
              frame_cnt_q <= frame_cnt_q + 8'd1;
            end else begin
              idx <= idx + 4'd1;
            end
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_butterfly_sequencer.sv
// Directed bench: a behavioural butterfly feeds the main sequencer, and a
// second instance with HOLD_CYCLES=4 is used for phase-length measurements.
`timescale 1ns/1ps

module tb_butterfly_sequencer;

  localparam int HOLD   = 8;
  localparam int HOLD4  = 4;
  localparam int BUDGET = 2000;

  logic clk = 1'b0;
  logic reset;
  logic rst4;

  int checks   = 0;
  int failures = 0;

  butterfly_sequencer_if bus ();
  butterfly_sequencer_if bus4 ();

  butterfly_sequencer #(.HOLD_CYCLES(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  butterfly_sequencer #(.HOLD_CYCLES(HOLD4)) dut4 (
    .clk   (clk),
    .reset (rst4),
    .bus   (bus4)
  );

  always #5 clk = ~clk;

  assign bus4.bfly_result = 8'h5A;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural butterfly: latches a word on every ReadyIn rise (w once after
  // reset, then Re b, Im b, Re a, Im a) and shows y, z on its LEDs.
  logic              m_prev, m_w_half, m_w_loaded;
  logic [2:0]        m_step;
  logic signed [7:0] wr, wi, br, bi, ar, ai;

  function automatic logic [7:0] bfly_out(input int sel, input logic signed [7:0] are,
                                          input logic signed [7:0] aim);
    int pr, pi;
    pr = (int'(wr) * int'(br) - int'(wi) * int'(bi)) >>> 7;
    pi = (int'(wr) * int'(bi) + int'(wi) * int'(br)) >>> 7;
    case (sel)
      0:       return 8'(int'(are) + pr);
      1:       return 8'(int'(aim) + pi);
      2:       return 8'(int'(are) - pr);
      default: return 8'(int'(aim) - pi);
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_prev          <= 1'b0;
      m_w_half        <= 1'b0;
      m_w_loaded      <= 1'b0;
      m_step          <= 3'd0;
      bus.bfly_result <= 8'h00;
    end else begin
      m_prev <= bus.bfly_ready;
      if (bus.bfly_ready && !m_prev) begin
        if (!m_w_loaded) begin
          if (!m_w_half) begin
            wr       <= bus.bfly_data;
            m_w_half <= 1'b1;
          end else begin
            wi         <= bus.bfly_data;
            m_w_loaded <= 1'b1;
          end
        end else begin
          case (m_step)
            3'd0: br <= bus.bfly_data;
            3'd1: bi <= bus.bfly_data;
            3'd2: ar <= bus.bfly_data;
            3'd3: begin
              ai              <= bus.bfly_data;
              bus.bfly_result <= bfly_out(0, ar, bus.bfly_data);
            end
            3'd4:    bus.bfly_result <= bfly_out(1, ar, ai);
            3'd5:    bus.bfly_result <= bfly_out(2, ar, ai);
            default: bus.bfly_result <= bfly_out(3, ar, ai);
          endcase
          m_step <= (m_step == 3'd6) ? 3'd0 : m_step + 3'd1;
        end
      end
    end
  end

  // Result consumer log: one {tag, data} entry per completed handshake.
  logic [9:0] results[$];

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.res_valid && bus.res_ready)
        results.push_back({bus.res_tag, bus.res_data});
    end
  end

  // Phase-length monitor for the HOLD_CYCLES=4 instance. A low run is the
  // LOW phase plus the single IDLE cycle in which the next word is taken.
  int   run4, highs4, viol4;
  logic prev4;
  bit   seen4;

  initial begin
    highs4 = 0;
    viol4  = 0;
    forever begin
      @(negedge clk);
      if (rst4) begin
        prev4 = 1'b0;
        run4  = 0;
        seen4 = 1'b0;
      end else begin
        if (bus4.bfly_ready !== prev4) begin
          if (prev4) begin
            check("h4_high_len", run4, HOLD4);
            highs4++;
          end else if (seen4) begin
            check("h4_low_len", run4, HOLD4 + 1);
          end
          if (bus4.bfly_ready) seen4 = 1'b1;
          prev4 = bus4.bfly_ready;
          run4  = 1;
        end else begin
          run4++;
        end
        if (bus4.in_ready && (bus4.bfly_ready || (seen4 && run4 <= HOLD4))) viol4++;
      end
    end
  end

  task automatic check_reset_values(input string pfx);
    check({pfx, "_bfly_ready"},  bus.bfly_ready,  1'b0);
    check({pfx, "_bfly_data"},   bus.bfly_data,   8'h00);
    check({pfx, "_in_ready"},    bus.in_ready,    1'b0);
    check({pfx, "_res_valid"},   bus.res_valid,   1'b0);
    check({pfx, "_res_data"},    bus.res_data,    8'h00);
    check({pfx, "_res_tag"},     bus.res_tag,     2'd0);
    check({pfx, "_w_pending"},   bus.w_pending,   1'b1);
    check({pfx, "_frame_count"}, bus.frame_count, 8'd0);
  endtask

  // Offers one word, waits for it to be taken, then checks the registered
  // word and the ReadyIn rise on the following cycle.
  task automatic send_word(input logic [7:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    #1;
    while (!bus.in_ready && n < BUDGET) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("word_accepted", bus.in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bfly_data_after_accept", bus.bfly_data, d);
    check("bfly_ready_rises", bus.bfly_ready, 1'b1);
  endtask

  task automatic expect_frame(input string name, input logic [7:0] re_a, input logic [7:0] im_a);
    int k;
    k = 0;
    while (results.size() < 4 && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    check({name, "_result_count"}, results.size(), 4);
    for (int i = 0; i < 4 && i < results.size(); i++)
      check($sformatf("%s_r%0d", name, i), results[i], {2'(i), (i % 2 == 0) ? re_a : im_a});
    results.delete();
  endtask

  task automatic wait_frame_count(input string name, input logic [7:0] n);
    int k;
    k = 0;
    while (bus.frame_count !== n && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    check({name, "_frame_count"}, bus.frame_count, n);
  endtask

  initial begin
    int bad, k;
    reset         = 1'b1;
    rst4          = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hAA;
    bus.res_ready = 1'b1;
    bus4.in_valid  = 1'b1;
    bus4.in_data   = 8'h11;
    bus4.res_ready = 1'b1;

    // Reset values with a word offered throughout, then the release cycle.
    repeat (3) @(negedge clk);
    check_reset_values("por");
    reset = 1'b0;
    #1;
    check("release_cycle_in_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    check("release_no_pulse", bus.bfly_ready, 1'b0);
    check("release_no_word", bus.bfly_data, 8'h00);

    // Frame 1 with twiddle w = 0.
    send_word(8'h00); send_word(8'h00);
    send_word(8'h11); send_word(8'h22);
    send_word(8'h20); send_word(8'h10);
    expect_frame("f1", 8'h20, 8'h10);
    wait_frame_count("f1", 8'd1);
    check("f1_w_pending", bus.w_pending, 1'b0);

    // Frame 2: no twiddle words.
    send_word(8'h05); send_word(8'h06);
    send_word(8'h40); send_word(8'hF0);
    expect_frame("f2", 8'h40, 8'hF0);
    wait_frame_count("f2", 8'd2);
    check("f2_w_pending", bus.w_pending, 1'b0);

    // Frame 3: source stalls 50 cycles before P2.
    send_word(8'h01); send_word(8'h02);
    k = 0;
    while (bus.bfly_ready && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    bad = 0;
    repeat (HOLD + 50) begin
      @(negedge clk);
      if (bus.bfly_ready || bus.bfly_data !== 8'h02) bad++;
    end
    check("f3_gap_violations", bad, 0);
    send_word(8'h30); send_word(8'h08);
    expect_frame("f3", 8'h30, 8'h08);
    wait_frame_count("f3", 8'd3);

    // Frame 4: consumer holds off after tag 0.
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    send_word(8'h03); send_word(8'h04);
    send_word(8'h7F); send_word(8'h80);
    k = 0;
    while (!bus.res_valid && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    check("f4_first_tag", bus.res_tag, 2'd0);
    check("f4_first_data", bus.res_data, 8'h7F);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.bfly_ready || !bus.res_valid || bus.res_data !== 8'h7F || bus.res_tag !== 2'd0)
        bad++;
    end
    check("f4_stall_violations", bad, 0);
    check("f4_nothing_handed_over", results.size(), 0);
    @(posedge clk);
    #1 bus.res_ready = 1'b1;
    expect_frame("f4", 8'h7F, 8'h80);
    wait_frame_count("f4", 8'd4);

    // Reset during the HIGH phase of P1, then a full w + frame sequence.
    send_word(8'h09); send_word(8'h0A);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("mid");
    reset = 1'b0;
    @(negedge clk);
    results.delete();
    send_word(8'h00); send_word(8'h00);
    send_word(8'h11); send_word(8'h22);
    send_word(8'h20); send_word(8'h10);
    expect_frame("f5", 8'h20, 8'h10);
    wait_frame_count("f5", 8'd1);
    check("f5_w_pending", bus.w_pending, 1'b0);

    // HOLD_CYCLES=4 instance: two frames with a word always on offer.
    @(negedge clk);
    rst4 = 1'b0;
    k = 0;
    while (bus4.frame_count !== 8'd2 && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    rst4 = 1'b1;
    check("h4_frame_count", bus4.frame_count, 8'd2);
    check("h4_high_phases", highs4, 16);
    check("h4_in_ready_outside_idle", viol4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/butterfly_sequencer.md
BUTTERFLY_SEQUENCER -- requirements
Module: butterfly_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 8, meaning cycles per high phase and per low phase of bfly_ready; legal range 4..255.
REQ-002 SHALL have port clk, input, 1, the single clock; every register is clocked on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset, shared with the downstream butterfly.
REQ-004 SHALL have port in_valid, input, 1, an operand word is offered.
REQ-005 SHALL have port in_ready, output, 1, the operand word is accepted this cycle.
REQ-006 SHALL have port in_data, input, 8, operand word (two's complement).
REQ-007 SHALL have port bfly_data, output, 8, drives the butterfly data input (SW).
REQ-008 SHALL have port bfly_ready, output, 1, level that replaces the debounced ReadyIn of the butterfly.
REQ-009 SHALL have port bfly_result, input, 8, butterfly LED output.
REQ-010 SHALL have port res_valid, output, 1, a result is held.
REQ-011 SHALL have port res_ready, input, 1, the consumer accepts the result.
REQ-012 SHALL have port res_data, output, 8, captured result.
REQ-013 SHALL have port res_tag, output, 2, result identity: 0 Re y, 1 Im y, 2 Re z, 3 Im z.
REQ-014 SHALL have port w_pending, output, 1, the twiddle is not yet loaded since reset.
REQ-015 SHALL have port frame_count, output, 8, completed frames, wrapping 255->0.

Function
REQ-016 SHALL generate pulses: each is HOLD_CYCLES cycles with bfly_ready=1, followed by HOLD_CYCLES cycles with bfly_ready=0.
REQ-017 First frame after reset: pulses W0 (Re w) and W1 (Im w), then P0..P6; later frames: P0..P6 only.
REQ-018 Pulse order is P0 Re b, P1 Im b, P2 Re a, P3 Im a, P4..P6 display pulses.
REQ-019 W0, W1 and P0..P3 consume one word each; P4..P6 consume none.
REQ-020 States: IDLE (bfly_ready=0, waiting to start the next pulse), HIGH, LOW; a pulse index register selects among 0..8.
REQ-021 A word-consuming pulse SHALL start only in a cycle where in_valid=1: in_ready=1 for exactly that cycle, in_data registered into bfly_data, and bfly_ready rises on the next cycle.
REQ-022 bfly_data SHALL stay constant from the rise of bfly_ready until the next word is accepted.
REQ-023 In the last HIGH cycle of P3, P4, P5 and P6, the block SHALL register bfly_result into res_data with res_tag 0, 1, 2 and 3 respectively, and set res_valid.
REQ-024 res_valid SHALL clear on the cycle after res_valid=1 and res_ready=1; res_data and res_tag SHALL hold while res_valid=1.
REQ-025 A pulse whose last HIGH cycle would capture SHALL NOT start while res_valid=1 and res_ready=0; the sequencer stays in IDLE with bfly_ready=0.
REQ-026 Accept and capture in the same cycle: the new result overwrites the old, and res_valid stays 1.
REQ-027 Reaching the end of the LOW phase of P6 SHALL increment frame_count and return the pulse index to P0.
REQ-028 w_pending SHALL clear at the end of the LOW phase of W1.
REQ-029 in_valid is ignored during HIGH, LOW, and IDLE states before display pulses; in_ready is 0 in all those cycles.
REQ-030 The HOLD counter is 8 bits and is reloaded at every phase change; no phase shall be shorter than HOLD_CYCLES.

Reset
REQ-031 On reset the outputs SHALL take these values: bfly_ready=0, bfly_data=0x00, in_ready=0, res_valid=0, res_data=0x00, res_tag=0, w_pending=1, frame_count=0, state IDLE, pulse index W0.
REQ-032 Reset mid-pulse SHALL abandon the frame; the next word accepted is treated as Re w.
REQ-033 In the cycle reset deasserts, no word is accepted.

Verification
REQ-034 Words 0x00,0x00 (w=0), then 0x11,0x22 (b), 0x20,0x10 (a), HOLD=8, res_ready=1, with the real butterfly connected -> results (tag:data) 0:0x20, 1:0x10, 2:0x20, 3:0x10; frame_count=1.
REQ-035 Second frame with 4 words 0x05,0x06,0x40,0xF0 and no w words -> 0:0x40, 1:0xF0, 2:0x40, 3:0xF0; w_pending stays 0.
REQ-036 in_valid withheld for 50 cycles before P2 -> bfly_ready held 0 and bfly_data unchanged throughout the 50 cycles; the frame then completes normally.
REQ-037 res_ready=0 after tag 0 -> P4 is not started until res_ready=1; tag 1 follows correctly.
REQ-038 Reset asserted in the HIGH phase of P1 -> all outputs return to their reset values on the next cycle; a full w+frame sequence then gives the REQ-034 results.
REQ-039 With HOLD=4, check every HIGH and LOW phase measures exactly 4 cycles, and in_ready is never asserted outside IDLE.
